// File: rtl/node_argmax.sv
// node_argmax
//   Collects one unsigned activation per output node, one node per
//   node_valid strobe. A frame is NUM_NODES nodes. The block tracks the
//   running maximum and its node index. At the end of the frame it
//   publishes the winning class.
//
// Ports
//   clk          system clock, all state updates on posedge
//   rst          asynchronous active-high reset
//   clr          synchronous frame abort; drops the partial frame
//   node_valid   node_in carries an activation this cycle
//   node_in      neuron activation (unsigned)
//   busy         a frame is partially collected
//   node_cnt     nodes accepted in the current frame
//   class_idx    index of the max activation of the last completed frame
//   class_val    the max activation value of that frame
//   class_valid  one-cycle pulse when class_idx/class_val update
module node_argmax #(
  parameter int NUM_NODES = 10,
  parameter int DATA_W    = 8,
  parameter int IDX_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              node_valid,
  input  logic [DATA_W-1:0] node_in,
  output logic              busy,
  output logic [IDX_W-1:0]  node_cnt,
  output logic [IDX_W-1:0]  class_idx,
  output logic [DATA_W-1:0] class_val,
  output logic              class_valid
);

  typedef enum logic {IDLE, COLLECT} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] max_val_q, max_val_d;
  logic [IDX_W-1:0]  max_idx_q, max_idx_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  class_idx_q, class_idx_d;
  logic [DATA_W-1:0] class_val_q, class_val_d;
  logic              class_valid_q, class_valid_d;
  logic              take;

  // Strict unsigned compare: on a tie the earlier (lower) index is kept.
  function automatic logic is_new_max(input logic [DATA_W-1:0] cand,
                                      input logic [DATA_W-1:0] cur);
    return cand > cur;
  endfunction

  always_comb begin
    state_d       = state_q;
    max_val_d     = max_val_q;
    max_idx_d     = max_idx_q;
    cnt_d         = cnt_q;
    class_idx_d   = class_idx_q;
    class_val_d   = class_val_q;
    class_valid_d = 1'b0;
    take          = is_new_max(node_in, max_val_q);

    // clr wins over node_valid. The incoming node, and any completion
    // it would cause, is dropped.
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (node_valid) begin
      case (state_q)
        IDLE: begin
          max_val_d = node_in;
          max_idx_d = '0;
          cnt_d     = IDX_W'(1);
          state_d   = COLLECT;
        end
        COLLECT: begin
          if (cnt_q == LAST_IDX) begin
            // Final node is compared straight into the result registers.
            class_val_d   = take ? node_in : max_val_q;
            class_idx_d   = take ? cnt_q : max_idx_q;
            class_valid_d = 1'b1;
            cnt_d         = '0;
            state_d       = IDLE;
          end else begin
            if (take) begin
              max_val_d = node_in;
              max_idx_d = cnt_q;
            end
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      max_val_q     <= '0;
      max_idx_q     <= '0;
      cnt_q         <= '0;
      class_idx_q   <= '0;
      class_val_q   <= '0;
      class_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      max_val_q     <= max_val_d;
      max_idx_q     <= max_idx_d;
      cnt_q         <= cnt_d;
      class_idx_q   <= class_idx_d;
      class_val_q   <= class_val_d;
      class_valid_q <= class_valid_d;
    end
  end

  assign busy        = (state_q == COLLECT);
  assign node_cnt    = cnt_q;
  assign class_idx   = class_idx_q;
  assign class_val   = class_val_q;
  assign class_valid = class_valid_q;

endmodule

// File: tb/tb_node_argmax.sv
module tb_node_argmax;

  localparam int NN = 10;

  typedef logic [7:0] frame_t [NN];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       node_valid = 1'b0;
  logic [7:0] node_in = 8'h00;
  logic       busy;
  logic [3:0] node_cnt;
  logic [3:0] class_idx;
  logic [7:0] class_val;
  logic       class_valid;

  int n_tests = 0;
  int n_fail  = 0;

  node_argmax #(.NUM_NODES(NN), .DATA_W(8), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .node_valid(node_valid),
    .node_in(node_in), .busy(busy), .node_cnt(node_cnt),
    .class_idx(class_idx), .class_val(class_val), .class_valid(class_valid)
  );

  always #5 clk = ~clk;

  // Reference model: the frame is a plain list of received activations.
  // When it holds NN values, the winner is the first occurrence of the
  // largest value.
  logic [7:0] frame_q[$];
  logic [3:0] exp_idx = '0;
  logic [7:0] exp_val = '0;
  logic       exp_valid = 1'b0;

  function automatic void argmax(input logic [7:0] q[$],
                                 output logic [3:0] idx,
                                 output logic [7:0] val);
    idx = 0;
    val = q[0];
    for (int i = 1; i < q.size(); i++)
      if (q[i] > val) begin
        val = q[i];
        idx = 4'(i);
      end
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      frame_q.delete();
      exp_idx   = '0;
      exp_val   = '0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = 1'b0;
      if (clr) begin
        frame_q.delete();
      end else if (node_valid) begin
        frame_q.push_back(node_in);
        if (frame_q.size() == NN) begin
          argmax(frame_q, exp_idx, exp_val);
          exp_valid = 1'b1;
          frame_q.delete();
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    check("cyc_class_valid", 32'(class_valid), 32'(exp_valid));
    check("cyc_class_idx",   32'(class_idx),   32'(exp_idx));
    check("cyc_class_val",   32'(class_val),   32'(exp_val));
    check("cyc_busy",        32'(busy),        32'(frame_q.size() != 0));
    check("cyc_node_cnt",    32'(node_cnt),    32'(frame_q.size()));
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Drives nodes lo..hi of a frame. gap idle cycles are inserted between
  // nodes but not after the last one. Returns at edge+1 of the last node.
  task automatic send(input frame_t f, input int lo, input int hi,
                      input int gap);
    for (int i = lo; i <= hi; i++) begin
      node_valid = 1'b1;
      node_in    = f[i];
      @(posedge clk); #1;
      node_valid = 1'b0;
      if (i != hi)
        repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic expect_result(input string tag, input logic [3:0] idx,
                               input logic [7:0] val);
    check({tag, "_valid"}, 32'(class_valid), 32'd1);
    check({tag, "_idx"},   32'(class_idx),   32'(idx));
    check({tag, "_val"},   32'(class_val),   32'(val));
    check({tag, "_busy"},  32'(busy),        32'd0);
    check({tag, "_model"}, {24'd0, exp_val, 4'd0, exp_idx} , {24'd0, val, 4'd0, idx});
  endtask

  frame_t f1, f_tie, f_last, f3;

  initial begin
    f1     = '{8'h05, 8'h12, 8'h7F, 8'h03, 8'h40, 8'h7E, 8'h00, 8'h11, 8'h22, 8'h33};
    f_tie  = '{8'h80, 8'h10, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    f_last = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    f3     = '{8'h10, 8'h20, 8'h30, 8'h90, 8'h50, 8'h60, 8'h70, 8'h80, 8'h8F, 8'h00};

    // Reset for 3 cycles, release 1 ns after an edge.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_class_valid", 32'(class_valid), 32'd0);
    check("rst_class_idx",   32'(class_idx),   32'd0);
    check("rst_class_val",   32'(class_val),   32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_node_cnt",    32'(node_cnt),    32'd0);
    @(posedge clk); #1;

    send(f1, 0, NN-1, 0);
    expect_result("frame1", 4'd2, 8'h7F);
    @(posedge clk); #1;

    send(f_tie, 0, NN-1, 0);
    expect_result("tie", 4'd0, 8'h80);
    @(posedge clk); #1;

    send(f_last, 0, NN-1, 0);
    expect_result("last", 4'd9, 8'hFF);
    @(posedge clk); #1;

    // Gapped frame, then node 0 of the next frame in the pulse cycle.
    send(f1, 0, NN-1, 2);
    expect_result("gapped", 4'd2, 8'h7F);
    send(f_last, 0, 0, 0);
    check("b2b_node_cnt", 32'(node_cnt), 32'd1);
    check("b2b_busy",     32'(busy),     32'd1);
    check("b2b_hold_idx", 32'(class_idx), 32'd2);
    send(f_last, 1, NN-1, 0);
    expect_result("b2b", 4'd9, 8'hFF);
    @(posedge clk); #1;

    // Abort after 4 nodes; the clr cycle also carries a node.
    send(f1, 0, 3, 0);
    clr = 1'b1; node_valid = 1'b1; node_in = 8'hFF;
    @(posedge clk); #1;
    clr = 1'b0; node_valid = 1'b0;
    check("clr_busy",        32'(busy),        32'd0);
    check("clr_node_cnt",    32'(node_cnt),    32'd0);
    check("clr_class_valid", 32'(class_valid), 32'd0);
    check("clr_class_idx",   32'(class_idx),   32'd9);
    check("clr_class_val",   32'(class_val),   32'hFF);
    send(f3, 0, NN-1, 0);
    expect_result("after_clr", 4'd3, 8'h90);
    @(posedge clk); #1;

    // clr together with the completing node suppresses the result.
    send(f1, 0, NN-2, 0);
    clr = 1'b1; node_valid = 1'b1; node_in = f1[NN-1];
    @(posedge clk); #1;
    clr = 1'b0; node_valid = 1'b0;
    check("clr_last_valid", 32'(class_valid), 32'd0);
    check("clr_last_val",   32'(class_val),   32'h90);
    check("clr_last_busy",  32'(busy),        32'd0);
    @(posedge clk); #1;

    // Async reset between edges after 6 nodes.
    send(f1, 0, 5, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",        32'(busy),        32'd0);
    check("arst_node_cnt",    32'(node_cnt),    32'd0);
    check("arst_class_idx",   32'(class_idx),   32'd0);
    check("arst_class_val",   32'(class_val),   32'd0);
    check("arst_class_valid", 32'(class_valid), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    send(f3, 0, NN-1, 0);
    expect_result("after_arst", 4'd3, 8'h90);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/node_argmax.md
Name: node_argmax

Overview:
- Downstream consumer of the MAC/accumulate neuron stage.
- Collects one 8-bit activation per output node, one node per valid strobe, over a frame of NUM_NODES nodes.
- Tracks the running maximum and its node index, then emits the predicted class for the handwritten-digit frame.
- Output feeds result logging and display.

Parameters:
- NUM_NODES, 10, nodes per frame (number of output classes), legal range 2..255
- DATA_W, 8, activation width; unsigned
- IDX_W, 4, class index width; must satisfy 2^IDX_W >= NUM_NODES

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous frame abort; discards the partial frame
- node_valid  in  1  node_in carries a valid activation this cycle
- node_in  in  DATA_W  neuron activation (mac stage out1)
- busy  out  1  a frame is partially collected
- node_cnt  out  IDX_W  nodes accepted in the current frame
- class_idx  out  IDX_W  index of the max activation in the last completed frame
- class_val  out  DATA_W  the max activation value
- class_valid  out  1  one-cycle pulse when class_idx/class_val update

Behaviour:
- Reset (async, rst=1):
  - All outputs are 0; state is IDLE.
  - Internal max_val, max_idx and node_cnt are 0.
  - Reset asserted mid-frame discards all partial data immediately.
- States:
  - IDLE (node_cnt=0, busy=0)
  - COLLECT (0 < node_cnt < NUM_NODES, busy=1)
- IDLE + node_valid:
  - max_val<=node_in, max_idx<=0, node_cnt<=1
  - Go to COLLECT. If NUM_NODES==1 this is unsupported (see range).
- COLLECT + node_valid:
  - Compare node_in > max_val, unsigned and strict.
  - If greater: max_val<=node_in, max_idx<=node_cnt.
  - node_cnt<=node_cnt+1.
- Frame completion: the node_valid with node_cnt==NUM_NODES-1 completes the frame.
  - On the next edge, class_idx and class_val take the final max, including this last node. The final compare is resolved combinationally into the output registers.
  - class_valid=1 for exactly that one cycle.
  - node_cnt<=0; state returns to IDLE.
  - Latency: last node accepted at edge N, so class_valid is high in cycle N+1.
- Tie: equal values do not replace the stored max, so the lowest index wins.
- Back-to-back frames:
  - node_valid in the cycle class_valid is high is accepted as node 0 of the next frame.
  - No bubble is required. class_idx/class_val still hold the previous result.
- Gaps: node_valid may drop for any number of cycles mid-frame; state and counts hold.
- clr:
  - clr=1 forces IDLE, node_cnt=0, busy=0. max_val and max_idx are don't-care.
  - class_idx, class_val and class_valid are unaffected; a pending pulse is suppressed only if clr coincides with the completing node.
  - clr has priority over node_valid in the same cycle; that node is dropped.
- Hold: class_idx and class_val keep their value until the next completed frame.
- No overflow is possible: node_cnt never exceeds NUM_NODES-1 in COLLECT.

Test Plan:
- Reset → outputs. Assert rst for 3 cycles, then release → class_valid=0, class_idx=0, class_val=0, busy=0, node_cnt=0.
- Single frame. Feed 10 nodes with valid every cycle: 05,12,7F,03,40,7E,00,11,22,33 → one cycle after the 10th node: class_valid=1, class_idx=2, class_val=7F, busy=0.
- Tie and first/last extremes:
  - Frame 80,10,80,...,00 → class_idx=0, class_val=80.
  - Frame 00×9 then FF → class_idx=9, class_val=FF.
- Gapped valid, then back-to-back:
  - Frame with node_valid toggling 1,0,0,1,... → same result as the contiguous run.
  - Next frame's node 0 driven in the class_valid cycle → accepted, node_cnt=1 next cycle, no lost node.
- Abort:
  - After 4 nodes, pulse clr together with node_valid → busy=0, node_cnt=0, class outputs unchanged.
  - Then a full 10-node frame → a correct single class_valid pulse.
- Async reset mid-frame: assert rst between clock edges after 6 nodes → outputs clear immediately without waiting for a clock edge; the following full frame produces the correct result.
